// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the rv32im multi-port register file.
//   - ABI register indices (x0..x4)
//   - default reset values for sp/gp
//   - win_port(): picks the priority write port from a per-port hit vector
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;
    localparam int REG_TP   = 4;

    localparam logic [31:0] SP_RESET_DEFAULT = 32'h7ffffff0;
    localparam logic [31:0] GP_RESET_DEFAULT = 32'h10000000;

    // Upper bound on write ports handled by win_port().
    localparam int MAX_PORTS = 32;

    // Highest-indexed set bit wins. Returns 0 when nothing hits, so callers
    // must qualify the result with |hits.
    function automatic int win_port(input logic [MAX_PORTS-1:0] hits);
        int w;
        w = 0;
        for (int i = 0; i < MAX_PORTS; i++)
            if (hits[i]) w = i;
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register.
//   clk, reset_n   : clock, synchronous active-low reset
//   alloc_en/addr  : mark a destination pending (x0 ignored)
//   wr_clr         : registers written this cycle (clears their busy bit)
//   flush          : clear every busy bit, drops a same-cycle alloc
//   busy_vec       : registered busy bits, bit 0 forced 0
//   busy_count     : population count of busy_vec
module regfile_scoreboard #(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic [NREGS-1:0] wr_clr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [AW:0]      busy_count
);

    logic [NREGS-1:0] alloc_vec;
    logic [NREGS-1:0] busy_nxt;

    // Alloc is applied after the write clear so a new producer issued in the
    // same cycle as the old one retiring keeps the register pending.
    always_comb begin
        alloc_vec = '0;
        if (alloc_en) alloc_vec[alloc_addr] = 1'b1;
        busy_nxt    = flush ? '0 : ((busy_vec & ~wr_clr) | alloc_vec);
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) busy_vec <= '0;
        else          busy_vec <= busy_nxt;
    end

    always_comb begin
        busy_count = '0;
        for (int r = 0; r < NREGS; r++)
            busy_count = busy_count + {{AW{1'b0}}, busy_vec[r]};
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with write-back
// scoreboard.
//   clk, reset_n          : clock, synchronous active-low reset
//   rs_addr/rs_data/rs_busy: NREAD combinational read ports
//   wr_en/wr_addr/wr_data : NWRITE write-back ports, highest index wins
//   alloc_en/alloc_addr   : mark destination pending
//   flush                 : clear all busy bits
//   busy_vec/busy_count   : registered scoreboard state
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data and
// busy clears onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int              XLEN     = 32,
    parameter  int              NREGS    = 32,
    parameter  int              NREAD    = 2,
    parameter  int              NWRITE   = 2,
    parameter  logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_DEFAULT),
    parameter  logic [XLEN-1:0] GP_RESET = XLEN'(GP_RESET_DEFAULT),
    localparam int              AW       = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NREAD-1:0][AW-1:0]     rs_addr,
    output logic [NREAD-1:0][XLEN-1:0]   rs_data,
    output logic [NREAD-1:0]             rs_busy,
    input  logic [NWRITE-1:0]            wr_en,
    input  logic [NWRITE-1:0][AW-1:0]    wr_addr,
    input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
    input  logic                         alloc_en,
    input  logic [AW-1:0]                alloc_addr,
    input  logic                         flush,
    output logic [NREGS-1:0]             busy_vec,
    output logic [AW:0]                  busy_count
);

    localparam int PW = (NWRITE > 1) ? $clog2(NWRITE) : 1;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           wr_clr;  // register written this cycle
    logic [NREGS-1:1][XLEN-1:0] wr_val;  // winning port's data per register

    // Per-register write arbitration; x0 has no write path at all.
    assign wr_clr[0] = 1'b0;
    for (genvar r = 1; r < NREGS; r++) begin : g_wr
        logic [MAX_PORTS-1:0] hits;
        logic [PW-1:0]        win;
        always_comb begin
            hits = '0;
            for (int i = 0; i < NWRITE; i++)
                hits[i] = wr_en[i] && (wr_addr[i] == AW'(r));
        end
        assign win       = PW'(win_port(hits));
        assign wr_clr[r] = |hits;
        assign wr_val[r] = wr_data[win];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= (r == REG_SP) ? SP_RESET :
                           (r == REG_GP) ? GP_RESET : '0;
        end else begin
            for (int r = 1; r < NREGS; r++)
                if (wr_clr[r]) regs[r] <= wr_val[r];
        end
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_clr     (wr_clr),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

    for (genvar j = 0; j < NREAD; j++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[j];
`ifdef REGFILE_BYPASS_EN
        logic [MAX_PORTS-1:0] hits;
        logic [PW-1:0]        win;
        logic                 hit;
        always_comb begin
            hits = '0;
            for (int i = 0; i < NWRITE; i++)
                hits[i] = wr_en[i] && (wr_addr[i] == a);
        end
        assign win = PW'(win_port(hits));
        assign hit = (|hits) && (a != '0);
        assign rs_data[j] = (a == '0) ? '0 : hit ? wr_data[win] : regs[a];
        // A same-cycle alloc re-arms the bit, so only forward the clear
        // when no new producer targets this register.
        assign rs_busy[j] = (hit && !(alloc_en && alloc_addr == a)) ? 1'b0 : busy_vec[a];
`else
        assign rs_data[j] = (a == '0) ? '0 : regs[a];
        assign rs_busy[j] = busy_vec[a];
`endif
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated write-back scoreboard, the next-generation architectural register store for the rv32im core. It provides NREAD combinational read ports, NWRITE write-back ports for ALU, load, and mul/div results, and one busy bit per register for issue-time hazard detection. Optional same-cycle write-to-read bypass is selectable at compile time. It sits between the decode/issue stage (reads and allocations) and the write-back stage (writes).

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, register count (power of two, ≥ 4); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (≥ 1)
- NWRITE, 2, number of write ports (≥ 1)
- SP_RESET, 32'h7ffffff0, reset value of x2 (sp)
- GP_RESET, 32'h10000000, reset value of x3 (gp)

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset; synchronous, active-low
- rs_addr  in  NREAD×AW  read addresses
- rs_data  out  NREAD×XLEN  read data
- rs_busy  out  NREAD  busy bit of each addressed register
- wr_en  in  NWRITE  write enables
- wr_addr  in  NWRITE×AW  write addresses
- wr_data  in  NWRITE×XLEN  write data
- alloc_en  in  1  mark a destination register pending
- alloc_addr  in  AW  register to mark pending
- flush  in  1  clear all busy bits
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0
- busy_count  out  AW+1  population count of busy_vec

## Operation
- Reset: sampled while reset_n = 0 at a rising edge.
  - All registers return to 0, except x2 = SP_RESET and x3 = GP_RESET.
  - All busy bits return to 0.
  - Reset takes priority over every write, alloc, and flush in that cycle.
  - Reset values apply at any time, including mid-operation with busy bits set.
- Writes: port i writes wr_data[i] to wr_addr[i] when wr_en[i] = 1 and wr_addr[i] ≠ 0.
  - x0 is never written and always reads 0.
  - If two ports target the same register in one cycle, the highest-indexed port wins.
- Busy tracking:
  - alloc_en with alloc_addr ≠ 0 sets the register's busy bit. Alloc of x0 is ignored.
  - A write to a register clears its busy bit.
  - A write to a non-busy register is legal and leaves the bit at 0.
  - Alloc and a write to the same register in the same cycle: the bit ends set, because the new producer overrides.
  - flush clears every busy bit. Flush and alloc in the same cycle: flush wins and the alloc is dropped.
  - Writes proceed normally during flush.
- Reads are combinational. rs_data[j] and rs_busy[j] reflect rs_addr[j] in the same cycle.
- busy_count is combinational from busy_vec and ranges from 0 to NREGS-1.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable from registered state after edge N.
- Busy set/clear latency: 1 cycle for busy_vec.
- No handshake. All inputs are single-cycle qualified by their enables.
- Read ports have no enable and never stall.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rs_data[j] returns the same-cycle wr_data of the winning port when that port writes rs_addr[j] (≠ 0).
  - rs_busy[j] reads 0 when a same-cycle write clears it and no same-cycle alloc targets it.
- REGFILE_BYPASS_EN undefined:
  - rs_data[j] and rs_busy[j] come purely from registered state.
  - A write becomes visible one cycle later.
- busy_vec and busy_count are always registered-state based, independent of the macro.

## Structure
- Package regfile_pkg holds:
  - ABI index constants REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP.
  - Default reset constants SP_RESET_DEFAULT and GP_RESET_DEFAULT.
  - A helper function for winning-port selection.
- Sub-module regfile_scoreboard owns the busy bits:
  - Inputs: alloc, write-clear vector, flush.
  - Outputs: busy_vec and busy_count.
- The top level holds the data array, write arbitration, read muxes, and bypass.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles, release. Read x1, x2, x3 → 0, 32'h7ffffff0, 32'h10000000. busy_vec = 0, busy_count = 0.
- Write collision: in one cycle, port 0 writes x5 = 32'hAAAA0000 and port 1 writes x5 = 32'h0000BBBB. Next cycle, x5 reads 32'h0000BBBB.
- x0 protection: write x0 = 32'hFFFFFFFF and alloc x0. x0 reads 0; busy_vec[0] = 0.
- Scoreboard:
  - Alloc x7 → busy_vec[7] = 1, busy_count = 1.
  - Same cycle, write x7 and alloc x7 → busy_vec[7] stays 1.
  - Write x7 alone → busy_vec[7] = 0.
  - Alloc x8 with flush → busy_vec = 0.
- Bypass: write x10 = 32'h12345678 with rs_addr[0] = 10 in the same cycle.
  - With REGFILE_BYPASS_EN: rs_data[0] = 32'h12345678 that cycle.
  - Without it: rs_data[0] holds the old value that cycle and reads 32'h12345678 the next.
- Mid-operation reset: set x2 = 5 and mark x4–x6 busy, then assert reset_n = 0 for one cycle. x2 = 32'h7ffffff0 and busy_count = 0.
